dma_burst_ctrl: RTL



---
 rtl/dma_burst_ctrl_pkg.sv | 6 +
 rtl/dma_burst_len.sv | 29 ++
 rtl/dma_burst_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/dma_burst_ctrl_pkg.sv
// dma_burst_ctrl_pkg: shared state encoding, AXI 4 KB page constant and default burst-length field width
package dma_burst_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, CALC, WAIT, XFER, DONE} state_t;
    localparam int PAGE_BYTES = 4096;
    localparam int AXI_LEN_W_DFLT = 8;
endpackage

// File: rtl/dma_burst_len.sv
// dma_burst_len: burst size = min(words_left, MAX_BURST[, words to next 4 KB page]); page term enabled by DMA_BURST_CTRL_4K_EN
module dma_burst_len
    import dma_burst_ctrl_pkg::*;
#(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_LEN_W  = AXI_LEN_W_DFLT,
    parameter int MAX_BURST  = 256,
    parameter int CNT_W      = 16,
    parameter int BPW        = 4
) (
    input  logic [CNT_W-1:0]      words_left,
    input  logic [AXI_ADDR_W-1:0] addr,
    output logic [AXI_LEN_W:0]    burst
);
    localparam int BW = AXI_LEN_W + 1;
    localparam int WW = ((CNT_W > BW) ? CNT_W : BW) + 14;
    logic [WW-1:0] capped;
    logic          unused_addr;
    assign unused_addr = ^addr;
    assign capped = (WW'(words_left) < WW'(MAX_BURST)) ? WW'(words_left) : WW'(MAX_BURST);
`ifdef DMA_BURST_CTRL_4K_EN
    // Words remaining before the next 4 KB page; 13 bits so a page-aligned address yields the full page.
    logic [12:0] to_4k;
    assign to_4k = (13'(PAGE_BYTES) - {1'b0, addr[11:0]}) / 13'(BPW);
    assign burst = (WW'(to_4k) < capped) ? BW'(to_4k) : BW'(capped);
`else
    assign burst = BW'(capped);
`endif
endmodule

// File: rtl/dma_burst_ctrl.sv
// dma_burst_ctrl: command-driven transfer sequencer splitting transfers into AXI bursts for the DMA engine native port (4 KB rule: DMA_BURST_CTRL_4K_EN)
module dma_burst_ctrl
    import dma_burst_ctrl_pkg::*;
#(
    parameter int DMA_DATA_W = 32,
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_LEN_W  = AXI_LEN_W_DFLT,
    parameter int MAX_BURST  = 256,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_dir,
    input  logic [AXI_ADDR_W-1:0]   cmd_addr,
    input  logic [CNT_W-1:0]        cmd_nwords,
    input  logic                    s_valid,
    input  logic [DMA_DATA_W-1:0]   s_data,
    output logic                    s_ready,
    output logic                    m_valid,
    output logic [DMA_DATA_W-1:0]   m_data,
    input  logic                    m_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    n_valid,
    output logic [AXI_ADDR_W-1:0]   n_address,
    output logic [DMA_DATA_W-1:0]   n_wdata,
    output logic [DMA_DATA_W/8-1:0] n_wstrb,
    input  logic [DMA_DATA_W-1:0]   n_rdata,
    input  logic                    n_ready,
    output logic [AXI_LEN_W-1:0]    n_dma_len,
    input  logic                    n_dma_ready,
    input  logic                    n_error
);
    localparam int BPW = DMA_DATA_W / 8;
    localparam int BW  = AXI_LEN_W + 1;

    state_t           state;
    logic             dir;
    logic [CNT_W-1:0] words_left;
    logic [BW-1:0]    beats;
    logic [BW-1:0]    burst;
    logic             xfer;
    logic             beat;

    dma_burst_len #(
        .AXI_ADDR_W (AXI_ADDR_W),
        .AXI_LEN_W  (AXI_LEN_W),
        .MAX_BURST  (MAX_BURST),
        .CNT_W      (CNT_W),
        .BPW        (BPW)
    ) u_len (
        .words_left (words_left),
        .addr       (n_address),
        .burst      (burst)
    );

    assign xfer      = (state == XFER);
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    // Reads only issue a beat when the output register can take it, so no beat is ever dropped.
    assign n_valid   = xfer & (dir ? s_valid : (~m_valid | m_ready));
    assign beat      = n_valid & n_ready;
    assign s_ready   = xfer & dir & n_ready;
    assign n_wdata   = (xfer & dir) ? s_data : '0;
    assign n_wstrb   = dir ? '1 : '0;

    // Sequencer: command latch, burst sizing, beat counting, error capture and done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            dir        <= 1'b0;
            n_address  <= '0;
            words_left <= '0;
            beats      <= '0;
            n_dma_len  <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && n_error) err <= 1'b1;
            case (state)
                IDLE: if (cmd_valid) begin
                    dir        <= cmd_dir;
                    n_address  <= cmd_addr;
                    words_left <= cmd_nwords;
                    err        <= 1'b0;
                    state      <= (cmd_nwords == '0) ? DONE : CALC;
                end
                CALC: begin
                    n_dma_len <= AXI_LEN_W'(burst - BW'(1));
                    beats     <= burst;
                    state     <= WAIT;
                end
                WAIT: if (n_dma_ready) state <= XFER;
                XFER: if (beat) begin
                    n_address  <= n_address + AXI_ADDR_W'(BPW);
                    words_left <= words_left - CNT_W'(1);
                    beats      <= beats - BW'(1);
                    // A burst always finishes; an error only suppresses the bursts after it.
                    if (beats == BW'(1))
                        state <= (words_left == CNT_W'(1) || err || n_error) ? DONE : CALC;
                end
                DONE: if (n_dma_ready) begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // One-entry read output register: captures each read beat, empties when the consumer takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (beat && !dir) begin
            m_valid <= 1'b1;
            m_data  <= n_rdata;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end
endmodule
